// File: rtl/color_pkg.sv
// Shared types and constants for the Color FSM and its command-side driver.
package color_pkg;

  // Colour held by the two-state Color FSM
  typedef enum logic {
    BLUE = 1'b0,
    RED  = 1'b1
  } color_state_t;

  // Status encodings reported by the Color FSM; 2'h0 and 2'h3 are invalid
  localparam logic [1:0] STATUS_BLUE = 2'h1;
  localparam logic [1:0] STATUS_RED  = 2'h2;

  // Command encodings accepted by the Color FSM
  localparam logic [1:0] CMD_TOGGLE = 2'h1;
  localparam logic [1:0] CMD_NOP    = 2'h0;

  // Driver controller states
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } drv_state_t;

  // Response codes returned to the requester
  typedef enum logic [1:0] {
    RESP_OK         = 2'd0,
    RESP_TIMEOUT    = 2'd1,
    RESP_BAD_STATUS = 2'd2
  } resp_code_t;

  // Status value the FSM reports when it holds the given colour
  function automatic logic [1:0] color_to_status(input color_state_t c);
    return (c == RED) ? STATUS_RED : STATUS_BLUE;
  endfunction

  // True only for the two legal status encodings
  function automatic logic status_valid(input logic [1:0] s);
    return (s == STATUS_BLUE) || (s == STATUS_RED);
  endfunction

endpackage

// File: rtl/color_drv_timer.sv
// Loadable down-counter with a zero flag that supervises one toggle attempt.
// It stops at zero instead of wrapping; it is always reloaded before use.
module color_drv_timer
  import color_pkg::*;
#(
  parameter int TIMEOUT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] LOAD_VAL = TW'(TIMEOUT);

  logic [TW-1:0] count;

  // Load takes priority over decrement; decrement holds at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (dec && (count != '0)) begin
      count <= count - TW'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/color_fsm_driver.sv
// Command-side controller for the Color FSM: accepts a target colour, toggles
// the FSM until its status reports that colour (with timeout and bounded
// retry), and returns an OK / TIMEOUT / BAD_STATUS response.
// Optional: define COLOR_DRV_STATS_EN to add toggle_count and err_count.
module color_fsm_driver
  import color_pkg::*;
#(
  parameter int TIMEOUT   = 4,
  parameter int MAX_RETRY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_color,
  output logic [1:0]  cmd,
  input  logic [1:0]  status,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [1:0]  resp_code
`ifdef COLOR_DRV_STATS_EN
  ,
  output logic [15:0] toggle_count,
  output logic [7:0]  err_count
`endif
);

  // A width of one keeps the counter legal when no retries are configured
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  drv_state_t   state;
  color_state_t target;
  logic [RW-1:0] retry;
  resp_code_t   code;
  logic         timer_zero;
  logic [1:0]   target_status;

  assign target_status = color_to_status(target);

  color_drv_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .load(state == S_ISSUE),
    .dec (state == S_WAIT),
    .zero(timer_zero)
  );

  // Main control FSM: handshake, check, toggle, supervise, respond
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      target <= BLUE;
      retry  <= '0;
      code   <= RESP_OK;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            target <= color_state_t'(req_color);
            retry  <= '0;
            state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (!status_valid(status)) begin
            code  <= RESP_BAD_STATUS;
            state <= S_RESP;
          end else if (status == target_status) begin
            code  <= RESP_OK;
            state <= S_RESP;
          end else begin
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (!status_valid(status)) begin
            code  <= RESP_BAD_STATUS;
            state <= S_RESP;
          end else if (status == target_status) begin
            code  <= RESP_OK;
            state <= S_RESP;
          end else if (timer_zero) begin
            if (retry < RETRY_MAX) begin
              retry <= retry + RW'(1);
              state <= S_ISSUE;
            end else begin
              code  <= RESP_TIMEOUT;
              state <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Handshake and command outputs decode the state register only
  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign cmd        = (state == S_ISSUE) ? CMD_TOGGLE : CMD_NOP;
  assign resp_code  = code;

`ifdef COLOR_DRV_STATS_EN
  // Saturating counters of toggles issued and non-OK responses taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      toggle_count <= '0;
      err_count    <= '0;
    end else begin
      if ((state == S_ISSUE) && (toggle_count != 16'hFFFF)) begin
        toggle_count <= toggle_count + 16'd1;
      end
      if ((state == S_RESP) && resp_ready && (code != RESP_OK) &&
          (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_color_fsm_driver.sv
// Directed testbench for color_fsm_driver with a behavioural Color FSM that
// can be overridden by a stub driving a fixed status value.
module tb_color_fsm_driver;
  import color_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_color = 1'b0;
  logic [1:0] cmd;
  logic [1:0] status;
  logic       resp_valid;
  logic       resp_ready = 1'b0;
  logic [1:0] resp_code;
`ifdef COLOR_DRV_STATS_EN
  logic [15:0] toggle_count;
  logic [7:0]  err_count;
`endif

  logic         stub_en = 1'b0;
  logic [1:0]   stub_status = 2'h2;
  color_state_t fsm_color;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  color_fsm_driver #(
    .TIMEOUT(4),
    .MAX_RETRY(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_color(req_color),
    .cmd(cmd),
    .status(status),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_code(resp_code)
`ifdef COLOR_DRV_STATS_EN
    ,
    .toggle_count(toggle_count),
    .err_count(err_count)
`endif
  );

  // Behavioural Color FSM: resets to Red, flips on a toggle command
  always @(posedge clk or posedge rst) begin
    if (rst) fsm_color <= RED;
    else if (cmd == CMD_TOGGLE) fsm_color <= color_state_t'(~fsm_color);
  end

  assign status = stub_en ? stub_status : ((fsm_color == RED) ? STATUS_RED : STATUS_BLUE);

  // Handshake at edge 0, then observe cycles 1.. (cycle n follows edge n-1)
  task automatic do_request(input logic color, input int bad_at,
                            output int resp_cyc, output int toggles, output int toggle_sum);
    resp_cyc = -1;
    toggles = 0;
    toggle_sum = 0;
    @(negedge clk);
    req_color = color;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 60 && resp_cyc < 0; c++) begin
      @(negedge clk);
      if (cmd == CMD_TOGGLE) begin
        toggles++;
        toggle_sum += c;
      end
      if (resp_valid) resp_cyc = c;
      if (c == bad_at) stub_status = 2'h3;
    end
  endtask

  task automatic take_resp();
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++; if (cmd !== 2'h0) begin errors++; $display("[TB] FAIL reset_cmd: got %0h expected 0", cmd); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_ready: got %0b expected 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_valid: got %0b expected 0", resp_valid); end
    checks++; if (resp_code !== 2'h0) begin errors++; $display("[TB] FAIL reset_resp_code: got %0h expected 0", resp_code); end
`ifdef COLOR_DRV_STATS_EN
    checks++; if (toggle_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_toggle_count: got %0d expected 0", toggle_count); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_err_count: got %0d expected 0", err_count); end
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_already_target();
    int rc, tg, ts;
    do_request(1'b1, 0, rc, tg, ts);
    checks++; if (rc !== 2) begin errors++; $display("[TB] FAIL same_resp_cycle: got %0d expected 2", rc); end
    checks++; if (tg !== 0) begin errors++; $display("[TB] FAIL same_toggles: got %0d expected 0", tg); end
    checks++; if (resp_code !== 2'h0) begin errors++; $display("[TB] FAIL same_code: got %0h expected 0", resp_code); end
    take_resp();
  endtask

  task automatic test_toggle(input int exp_toggle_count);
    int rc, tg, ts;
    do_request(1'b0, 0, rc, tg, ts);
    checks++; if (rc !== 4) begin errors++; $display("[TB] FAIL toggle_resp_cycle: got %0d expected 4", rc); end
    checks++; if (tg !== 1) begin errors++; $display("[TB] FAIL toggle_pulses: got %0d expected 1", tg); end
    checks++; if (ts !== 2) begin errors++; $display("[TB] FAIL toggle_pulse_cycle: got %0d expected 2", ts); end
    checks++; if (resp_code !== 2'h0) begin errors++; $display("[TB] FAIL toggle_code: got %0h expected 0", resp_code); end
    checks++; if (status !== 2'h1) begin errors++; $display("[TB] FAIL toggle_status: got %0h expected 1", status); end
`ifdef COLOR_DRV_STATS_EN
    checks++; if (toggle_count !== 16'(exp_toggle_count)) begin errors++; $display("[TB] FAIL toggle_count: got %0d expected %0d", toggle_count, exp_toggle_count); end
`else
    if (exp_toggle_count < 0) $display("[TB] note: negative toggle expectation");
`endif
    take_resp();
  endtask

  task automatic test_timeout();
    int rc, tg, ts;
    stub_en = 1'b1;
    stub_status = 2'h2;
    do_request(1'b0, 0, rc, tg, ts);
    checks++; if (rc !== 20) begin errors++; $display("[TB] FAIL timeout_resp_cycle: got %0d expected 20", rc); end
    checks++; if (tg !== 3) begin errors++; $display("[TB] FAIL timeout_pulses: got %0d expected 3", tg); end
    checks++; if (ts !== 24) begin errors++; $display("[TB] FAIL timeout_pulse_cycles_sum: got %0d expected 24", ts); end
    checks++; if (resp_code !== 2'h1) begin errors++; $display("[TB] FAIL timeout_code: got %0h expected 1", resp_code); end
`ifdef COLOR_DRV_STATS_EN
    checks++; if (toggle_count !== 16'd4) begin errors++; $display("[TB] FAIL timeout_toggle_count: got %0d expected 4", toggle_count); end
`endif
    take_resp();
`ifdef COLOR_DRV_STATS_EN
    checks++; if (err_count !== 8'd1) begin errors++; $display("[TB] FAIL timeout_err_count: got %0d expected 1", err_count); end
`endif
  endtask

  task automatic test_bad_status_and_hold();
    int rc, tg, ts;
    stub_en = 1'b1;
    stub_status = 2'h2;
    do_request(1'b0, 3, rc, tg, ts);
    checks++; if (rc !== 4) begin errors++; $display("[TB] FAIL bad_resp_cycle: got %0d expected 4", rc); end
    checks++; if (resp_code !== 2'h2) begin errors++; $display("[TB] FAIL bad_code: got %0h expected 2", resp_code); end
    checks++; if (cmd !== 2'h0) begin errors++; $display("[TB] FAIL bad_cmd: got %0h expected 0", cmd); end
    checks++; if (tg !== 1) begin errors++; $display("[TB] FAIL bad_pulses: got %0d expected 1", tg); end
    req_color = 1'b0;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (resp_valid !== 1'b1) begin errors++; $display("[TB] FAIL hold_resp_valid[%0d]: got %0b expected 1", i, resp_valid); end
      checks++; if (resp_code !== 2'h2) begin errors++; $display("[TB] FAIL hold_resp_code[%0d]: got %0h expected 2", i, resp_code); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL hold_req_ready[%0d]: got %0b expected 0", i, req_ready); end
    end
    @(negedge clk);
    resp_ready = 1'b1;
    req_valid = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL take_req_ready_same_cycle: got %0b expected 0", req_ready); end
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL take_req_ready_next: got %0b expected 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL take_resp_valid_next: got %0b expected 0", resp_valid); end
`ifdef COLOR_DRV_STATS_EN
    checks++; if (err_count !== 8'd2) begin errors++; $display("[TB] FAIL bad_err_count: got %0d expected 2", err_count); end
`endif
    stub_status = 2'h2;
  endtask

  task automatic test_reset_mid();
    stub_en = 1'b1;
    stub_status = 2'h2;
    @(negedge clk);
    req_color = 1'b0;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 3; c++) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (cmd !== 2'h0) begin errors++; $display("[TB] FAIL midrst_cmd: got %0h expected 0", cmd); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_resp_valid: got %0b expected 0", resp_valid); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_req_ready: got %0b expected 1", req_ready); end
`ifdef COLOR_DRV_STATS_EN
    checks++; if (toggle_count !== 16'd0) begin errors++; $display("[TB] FAIL midrst_toggle_count: got %0d expected 0", toggle_count); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("[TB] FAIL midrst_err_count: got %0d expected 0", err_count); end
`endif
    stub_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    $display("[TB] color_fsm_driver directed test start");
    test_reset();
    test_already_target();
    test_toggle(1);
    test_timeout();
    test_bad_status_and_hold();
    test_reset_mid();
    test_toggle(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/color_fsm_driver.md
# color_fsm_driver

Command-side controller for the two-state Color FSM: it accepts a requested target color over a valid/ready port and drives the FSM's 2-bit command input until the FSM's 2-bit status output reports that color. It issues toggles, supervises each one with a timeout and bounded retry, and returns a completion or error response. It sits between a host or register interface and the Color FSM instance, in the same clock domain.

## Interface
- TIMEOUT, 4: cycles to wait in WAIT for status to match after a toggle; must be ≥1.
- MAX_RETRY, 2: extra toggle attempts after the first timeout before reporting an error.
- clk  in  1  clock; all flops rise on posedge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  target-color request valid.
- req_ready  out  1  request accepted when high with req_valid.
- req_color  in  1  target: 0 = Blue, 1 = Red.
- cmd  out  2  to the FSM's command input: 2'h1 = toggle, 2'h0 = no-op.
- status  in  2  from the FSM's status output: 2'h1 = Blue, 2'h2 = Red; 2'h0 and 2'h3 are invalid.
- resp_valid  out  1  response valid; held until taken.
- resp_ready  in  1  response consumer ready.
- resp_code  out  2  0 = OK, 1 = TIMEOUT, 2 = BAD_STATUS; valid only while resp_valid is high.

## Operation
- States: IDLE, CHECK, ISSUE, WAIT, RESP.
- IDLE
  - req_ready = 1.
  - On req_valid & req_ready, register req_color as the target, clear the retry counter, go to CHECK.
- CHECK
  - status invalid → RESP, code BAD_STATUS.
  - status equals target → RESP, code OK; no toggle is issued.
  - Otherwise → ISSUE.
- ISSUE
  - cmd = 2'h1 for exactly this one cycle.
  - Load timer = TIMEOUT, go to WAIT.
- WAIT
  - cmd = 2'h0.
  - Priority order:
    1. status invalid → RESP, BAD_STATUS.
    2. status equals target → RESP, OK.
    3. timer == 0 and retry < MAX_RETRY → retry+1, go to ISSUE.
    4. timer == 0 and retry == MAX_RETRY → RESP, TIMEOUT.
    5. Otherwise timer−1.
- RESP
  - resp_valid = 1 with resp_code stable.
  - On resp_ready → IDLE.
  - req_ready = 0 in every state except IDLE.
- cmd = 2'h0 in every state other than ISSUE, and is decoded from the state register only.
- Timer width: $clog2(TIMEOUT+1). Retry width: $clog2(MAX_RETRY+1). No wrap; both are reloaded or cleared before use.

## Timing
- Reset values: state = IDLE, cmd = 2'h0, req_ready = 1 (IDLE decode), resp_valid = 0, resp_code = 0, timer = 0, retry = 0.
- Reset asserted mid-operation aborts immediately to these values; the pending response is lost.
- Request handshake at edge 0, toggle needed:
  - cycle 1: CHECK.
  - cycle 2: ISSUE, cmd = 2'h1.
  - cycle 3: FSM status updates; WAIT sees the match.
  - cycle 4: resp_valid = 1.
- Request handshake at edge 0, already at target: resp_valid = 1 in cycle 2.
- WAIT lasts at most TIMEOUT+1 cycles per attempt.
- Worst case to TIMEOUT response: 2 + (MAX_RETRY+1)·(TIMEOUT+2) cycles after the handshake.
- Response taken at edge N: IDLE in cycle N+1, so req_ready = 1 no earlier than N+1. There is no same-cycle response/request overlap.
- req_valid while not in IDLE is ignored; the requester must hold it.
- status that changes to the target during WAIT before a retry is accepted as OK.

## Configuration
- COLOR_DRV_STATS_EN defined:
  - Adds output toggle_count [15:0]: saturating count of ISSUE cycles since reset, saturates at 16'hFFFF.
  - Adds output err_count [7:0]: saturating count of non-OK responses taken.
  - Both reset to 0.
- Undefined: neither port nor their counters exist; all other behaviour is identical.

## Structure
- Shared package color_pkg holds:
  - Color_state enum (Blue = 1'h0, Red = 1'h1).
  - Constants STATUS_BLUE = 2'h1, STATUS_RED = 2'h2, CMD_TOGGLE = 2'h1, CMD_NOP = 2'h0.
  - Driver state enum.
  - Response code enum.
- The Color FSM imports the same status and command constants.
- One sub-module: color_drv_timer.
  - Loadable down-counter with zero flag; parameter TIMEOUT; inputs load and dec.
  - Instantiated once.

## Test plan
- Reset releases with FSM in Red; request Red → no cmd toggle; resp_valid in cycle 2 with code 0.
- Request Blue from Red with the real FSM attached → cmd = 2'h1 for exactly one cycle (cycle 2); status becomes 2'h1; resp_code 0 in cycle 4.
- Stubbed FSM whose status stays 2'h2 (TIMEOUT=4, MAX_RETRY=2) → exactly 3 toggle pulses; resp_code 1 at cycle 2+3·6 = 20.
- status forced to 2'h3 during WAIT → next cycle resp_valid with code 2; cmd stays 2'h0.
- resp_ready held low 5 cycles → resp_valid and resp_code stable; req_valid ignored; req_ready rises the cycle after resp_ready.
- rst pulsed in the WAIT cycle → cmd = 2'h0, resp_valid = 0, req_ready = 1 immediately. With COLOR_DRV_STATS_EN: toggle_count = 0 after reset and 1 after one toggle.
